cpu_core_hs: RTL and testbench

//  Parametrised successor of the fixed-period 4-bit-opcode CPU core. It runs the same ISA but

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cpu_regfile.sv | 29 ++
 rtl/cpu_core_hs.sv | 187 ++++++++++++++++++
 tb/tb_cpu_core_hs.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, instruction field positions and FSM states for cpu_core_hs
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LI   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_LI64 = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_SAR  = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_SUBI = 4'hD;
  localparam logic [3:0] OP_IN   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI  = 63;
  localparam int OP_LO  = 60;
  localparam int RD_HI  = 59;
  localparam int RD_LO  = 57;
  localparam int RS_HI  = 56;
  localparam int RS_LO  = 54;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    OUT   = 3'd2,
    INW   = 3'd3,
    HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - 8 x XLEN register file, two async read ports, one sync write port
module cpu_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [2:0]      rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic            we,
  input  logic [2:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/cpu_core_hs.sv
// rtl/cpu_core_hs.sv - parametrised 4-bit-opcode core with FSM sequencing and valid/ready I/O
module cpu_core_hs
  import cpu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 8,
  parameter int IO_ADDR = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [63:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic            halted,
  output logic            retire,
  output logic [PC_W-1:0] dbg_pc
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [DMEM_AW-1:0] IO_A = DMEM_AW'(IO_ADDR);

  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      wait_rd_q;
  logic [XLEN-1:0] out_data_q;
  logic            out_valid_q;
  logic            retire_q, retire_d;

  logic [3:0]         op;
  logic [2:0]         rd, rs;
  logic [15:0]        imm16;
  logic [DMEM_AW-1:0] addr;
  logic [XLEN-1:0]    rd_val, rs_val, li64_val, ld_val;
  logic [XLEN-1:0]    shl_val, shr_val, sar_val;
  logic               big_sh, is_io_st, dmem_we;
  logic [SH_W-1:0]    sh_amt;
  logic               rf_we;
  logic [2:0]         rf_wa;
  logic [XLEN-1:0]    rf_wd;

  logic [XLEN-1:0] dmem [2**DMEM_AW];

  assign op     = imem_rdata[OP_HI:OP_LO];
  assign rd     = imem_rdata[RD_HI:RD_LO];
  assign rs     = imem_rdata[RS_HI:RS_LO];
  assign imm16  = imem_rdata[IMM_HI:IMM_LO];
  assign addr   = imem_rdata[DMEM_AW-1:0];

  cpu_regfile #(.XLEN(XLEN)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (rd),
    .ra_data (rd_val),
    .rb_addr (rs),
    .rb_data (rs_val),
    .we      (rf_we),
    .wa      (rf_wa),
    .wd      (rf_wd)
  );

  always_comb begin
    li64_val = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < 64) li64_val[i] = imem_rdata[i];
    end
  end

  // Shift amount is the whole register, so anything >= XLEN saturates.
  assign big_sh  = (rs_val >= XLEN'(XLEN));
  assign sh_amt  = rs_val[SH_W-1:0];
  assign shl_val = big_sh ? '0 : (rd_val << sh_amt);
  assign shr_val = big_sh ? '0 : (rd_val >> sh_amt);
  assign sar_val = big_sh ? {XLEN{rd_val[XLEN-1]}} : XLEN'($signed(rd_val) >>> sh_amt);

  assign is_io_st = (op == OP_ST) && (addr == IO_A);
  assign dmem_we  = (state_q == EXEC) && (op == OP_ST);
  assign ld_val   = dmem[addr];

  always_ff @(posedge clk) begin
    if (dmem_we) dmem[addr] <= rd_val;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = rd;
    rf_wd    = '0;
    case (state_q)
      FETCH: state_d = EXEC;
      EXEC: begin
        state_d  = FETCH;
        pc_d     = pc_q + 1'b1;
        retire_d = 1'b1;
        case (op)
          OP_ADD:  begin rf_we = 1'b1; rf_wd = rd_val + rs_val; end
          OP_SUB:  begin rf_we = 1'b1; rf_wd = rd_val - rs_val; end
          OP_LI:   begin rf_we = 1'b1; rf_wd = XLEN'(imm16); end
          OP_LD:   begin rf_we = 1'b1; rf_wd = ld_val; end
          OP_LI64: begin rf_we = 1'b1; rf_wd = li64_val; end
          OP_SHL:  begin rf_we = 1'b1; rf_wd = shl_val; end
          OP_SHR:  begin rf_we = 1'b1; rf_wd = shr_val; end
          OP_SAR:  begin rf_we = 1'b1; rf_wd = sar_val; end
          OP_ADDI: begin rf_we = 1'b1; rf_wd = rd_val + XLEN'(imm16); end
          OP_SUBI: begin rf_we = 1'b1; rf_wd = rd_val - XLEN'(imm16); end
          OP_ST: begin
            if (is_io_st) begin
              state_d  = OUT;
              pc_d     = pc_q;
              retire_d = 1'b0;
            end
          end
          OP_JZ:  if (rd_val == '0) pc_d = pc_q + PC_W'($signed(imm16[7:0]));
          OP_JMP: pc_d = PC_W'(imm16);
          OP_IN: begin
            state_d  = INW;
            pc_d     = pc_q;
            retire_d = 1'b0;
          end
          OP_HALT: begin
            state_d = HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      OUT: begin
        if (out_ready) begin
          state_d  = FETCH;
          pc_d     = pc_q + 1'b1;
          retire_d = 1'b1;
        end
      end
      INW: begin
        if (in_valid) begin
          state_d  = FETCH;
          pc_d     = pc_q + 1'b1;
          retire_d = 1'b1;
          rf_we    = 1'b1;
          rf_wa    = wait_rd_q;
          rf_wd    = in_data;
        end
      end
      HALT:    ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      retire_q    <= 1'b0;
      wait_rd_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
      if (state_q == EXEC) wait_rd_q <= rd;
      // out_data is captured once and held until the consumer accepts it.
      if (state_q == EXEC && is_io_st) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rd_val;
      end else if (state_q == OUT && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign imem_addr = pc_q;
  assign dbg_pc    = pc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_ready  = (state_q == INW);
  assign halted    = (state_q == HALT);
  assign retire    = retire_q;

endmodule

// File: tb/tb_cpu_core_hs.sv
// tb/tb_cpu_core_hs.sv - scoreboard bench for cpu_core_hs with directed programs
module tb_cpu_core_hs;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [63:0] imem_rdata;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic        halted, retire;
  logic [7:0]  dbg_pc;

  logic [63:0] rom [256];
  logic [63:0] exp_q [$];
  int n_vec = 0;
  int n_bad = 0;
  int ret_total = 0;
  int out_total = 0;
  int ret_base, out_base;

  cpu_core_hs #(.XLEN(64), .PC_W(8), .DMEM_AW(8), .IO_ADDR(255)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .halted     (halted),
    .retire     (retire),
    .dbg_pc     (dbg_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  function automatic logic [63:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [15:0] imm);
    return {op, rd, rs, 38'd0, imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(OP_HALT, 0, 0, 0);
  endtask

  task automatic start();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ret_base = ret_total;
    out_base = out_total;
  endtask

  function automatic logic sel_sig(input int sel);
    return (sel == 0) ? halted : (sel == 1) ? out_valid : in_ready;
  endfunction

  task automatic wait_sig(input int sel, input int budget, input string name);
    int n = 0;
    while (!sel_sig(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, sel_sig(sel), 1);
  endtask

  task automatic finish_run(input string name, input int exp_ret, input int exp_out,
                            input logic [7:0] exp_pc);
    wait_sig(0, 600, {name, "_halt"});
    repeat (3) @(negedge clk);
    chk({name, "_retire"}, ret_total - ret_base, exp_ret);
    chk({name, "_outs"}, out_total - out_base, exp_out);
    chk({name, "_pc"}, dbg_pc, exp_pc);
  endtask

  task automatic prog_basic();
    clear_rom();
    rom[0] = enc(OP_LI, 1, 0, 5);
    rom[1] = enc(OP_LI, 2, 0, 7);
    rom[2] = enc(OP_ADD, 1, 2, 0);
    rom[3] = enc(OP_ST, 1, 0, 255);
    rom[4] = enc(OP_HALT, 0, 0, 0);
  endtask

  task automatic prog_in();
    clear_rom();
    rom[0] = enc(OP_IN, 3, 0, 0);
    rom[1] = enc(OP_ST, 3, 0, 255);
    rom[2] = enc(OP_HALT, 0, 0, 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    clear_rom();

    // Monitor: samples 1 time unit after the falling edge so same-edge input changes are seen.
    fork
      forever begin
        @(negedge clk);
        #1;
        if (rst_n && retire) ret_total++;
        if (rst_n && out_valid && out_ready) begin
          out_total++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL out_unexpected: got %0h expected no output", out_data);
          end else begin
            chk("out_data", out_data, exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    chk("rst_pc", dbg_pc, 0);
    chk("rst_out_data", out_data, 0);

    // 1: basic program, consumer always ready
    prog_basic();
    out_ready = 1'b1;
    exp_q.push_back(64'd12);
    start();
    finish_run("t1", 5, 1, 8'd4);

    // 2: consumer stalls for 10 cycles
    out_ready = 1'b0;
    exp_q.push_back(64'd12);
    start();
    wait_sig(1, 100, "t2_outv");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid && out_data == 64'd12 && dbg_pc == 8'd3) cnt++;
    end
    chk("t2_stall_hold", cnt, 10);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_accept_first", out_valid, 0);
    finish_run("t2", 5, 1, 8'd4);

    // 3: blocking IN, producer arrives late
    prog_in();
    exp_q.push_back(64'hDEAD);
    start();
    wait_sig(2, 100, "t3_inr");
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready && dbg_pc == 8'd0) cnt++;
    end
    chk("t3_inw_hold", cnt, 6);
    in_data = 64'hDEAD;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_in_accept", in_ready, 0);
    finish_run("t3", 3, 1, 8'd2);

    // 4: countdown loop with forward JZ
    clear_rom();
    rom[0] = enc(OP_LI, 0, 0, 3);
    rom[1] = enc(OP_SUBI, 0, 0, 1);
    rom[2] = enc(OP_JZ, 0, 0, 16'h0002);
    rom[3] = enc(OP_JMP, 0, 0, 16'h0001);
    rom[4] = enc(OP_ST, 0, 0, 255);
    rom[5] = enc(OP_HALT, 0, 0, 0);
    exp_q.push_back(64'd0);
    start();
    finish_run("t4", 11, 1, 8'd5);

    // 4b: JZ with offset -1 branches backwards onto HALT
    clear_rom();
    rom[0] = enc(OP_LI, 1, 0, 1);
    rom[1] = enc(OP_JMP, 0, 0, 16'h0003);
    rom[2] = enc(OP_HALT, 0, 0, 0);
    rom[3] = enc(OP_JZ, 0, 0, 16'h00FF);
    rom[4] = enc(OP_ST, 1, 0, 255);
    start();
    finish_run("t4b", 4, 0, 8'd2);

    // 5: shift boundaries, LI64, dmem store/load
    clear_rom();
    rom[0]  = enc(OP_LI, 1, 0, 1);
    rom[1]  = enc(OP_LI, 2, 0, 64);
    rom[2]  = enc(OP_SHL, 1, 2, 0);
    rom[3]  = enc(OP_ST, 1, 0, 255);
    rom[4]  = enc(OP_LI64, 0, 0, 0);
    rom[5]  = enc(OP_LI, 2, 0, 4);
    rom[6]  = enc(OP_SAR, 0, 2, 0);
    rom[7]  = enc(OP_ST, 0, 0, 255);
    rom[8]  = enc(OP_SHR, 0, 2, 0);
    rom[9]  = enc(OP_ST, 0, 0, 255);
    rom[10] = enc(OP_LI64, 0, 0, 0);
    rom[11] = enc(OP_LI, 2, 0, 100);
    rom[12] = enc(OP_SAR, 0, 2, 0);
    rom[13] = enc(OP_ST, 0, 0, 255);
    rom[14] = enc(OP_ADDI, 5, 0, 16'h1234);
    rom[15] = enc(OP_ST, 5, 0, 10);
    rom[16] = enc(OP_LD, 4, 0, 10);
    rom[17] = enc(OP_ST, 4, 0, 255);
    rom[18] = enc(OP_HALT, 0, 0, 0);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'hF800_0000_0000_0000);
    exp_q.push_back(64'h0F80_0000_0000_0000);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    exp_q.push_back(64'h1234);
    start();
    finish_run("t5", 19, 5, 8'd18);

    // 6: async reset while in OUT, then clean restart
    prog_basic();
    out_ready = 1'b0;
    start();
    wait_sig(1, 100, "t6_outv");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid_rst", out_valid, 0);
    chk("t6_pc_rst", dbg_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ret_base = ret_total;
    out_base = out_total;
    out_ready = 1'b1;
    exp_q.push_back(64'd12);
    finish_run("t6", 5, 1, 8'd4);

    // 6b: async reset while in INW, producer then holds in_valid high throughout
    prog_in();
    start();
    wait_sig(2, 100, "t6b_inr");
    #2 rst_n = 1'b0;
    #1;
    chk("t6b_in_ready_rst", in_ready, 0);
    chk("t6b_pc_rst", dbg_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ret_base = ret_total;
    out_base = out_total;
    in_data = 64'h1234_5678;
    in_valid = 1'b1;
    exp_q.push_back(64'h1234_5678);
    finish_run("t6b", 3, 1, 8'd2);
    in_valid = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
